// File: rtl/logicnet_lut_neuron_cfg.sv
// Runtime-loadable LogicNet truth-table neuron: IN_BITS-wide index into a
// 2^IN_BITS x OUT_BITS table, registered result behind a valid/ready handshake.
module logicnet_lut_neuron_cfg #(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                out_ready,
  input  logic                cfg_we,
  input  logic [IN_BITS-1:0]  cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_fill,
  output logic                cfg_busy
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic [IN_BITS-1:0]  fill_cnt;
  logic [OUT_BITS-1:0] fill_val;
  logic [OUT_BITS-1:0] lut_mem [DEPTH];
  logic                xfer;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_fill) state_d = FILL;
      FILL:    if (fill_cnt == IN_BITS'(DEPTH - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cfg_busy = (state_q == FILL);
  assign in_ready = rst_n && (state_q == IDLE) && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  // Reads use the pre-edge table contents, so a same-cycle write to the
  // queried address returns the old entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fill_cnt  <= '0;
      fill_val  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < DEPTH; i++) lut_mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FILL) begin
        lut_mem[fill_cnt] <= fill_val;
        fill_cnt          <= fill_cnt + 1'b1;
      end else if (cfg_fill) begin
        fill_val <= cfg_data;
        fill_cnt <= '0;
      end else if (cfg_we) begin
        lut_mem[cfg_addr] <= cfg_data;
      end

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= lut_mem[in_data];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
